seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd10_000, giving clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port digits_in  input  16  four BCD digits; [3:0] is digit0 (least significant), [15:12] is digit3.
REQ-005 SHALL have port load  input  1  one-cycle strobe that captures digits_in.
REQ-006 SHALL have port seg_out  output  7  segments a..g, active-high, registered.
REQ-007 SHALL have port an_out  output  4  one-hot digit enable, active-high, registered; bit i selects digit i.
REQ-008 SHALL have port busy  output  1  high while a captured value waits for a frame boundary.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-010 SHALL keep a 16-bit prescaler counting 0..SCAN_DIV-1; on reaching SCAN_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
REQ-011 SHALL keep a 2-bit slot index incremented on each tick, wrapping 3->0.
REQ-012 SHALL define a frame boundary as a tick while slot index == 3; frame_done SHALL be high exactly that cycle.
REQ-013 SHALL hold a pending register and a display register; load SHALL write digits_in to pending and set busy.
REQ-014 SHALL copy pending to display and clear busy on a frame boundary; display SHALL never change mid-frame (no tearing).
REQ-015 load while busy SHALL overwrite pending (latest wins); busy stays high.
REQ-016 load coincident with a frame boundary SHALL write digits_in directly to display, leave busy low.
REQ-017 an_out SHALL be registered from the slot index: one cycle after index becomes i, an_out == (1<<i).
REQ-018 seg_out SHALL be registered in the same cycle as an_out, showing the decode of display digit i.
REQ-019 Decode SHALL map 0..9 to standard gfedcba patterns (0 -> 7'b0111111, 1 -> 7'b0000110, 8 -> 7'b1111111); values 10..15 SHALL yield 7'b0000000.
REQ-020 Prescaler and slot index SHALL run continuously; load, busy and frame_done SHALL not stall scanning.

Reset
REQ-021 While rst_n low: prescaler 0, slot index 0, pending and display 0, busy 0, frame_done 0, an_out 4'b0000, seg_out 7'b0000000.
REQ-022 First cycle after rst_n rises SHALL give an_out 4'b0001, seg_out 7'b0111111.
REQ-023 rst_n low mid-frame SHALL discard pending and display without a frame_done pulse.

Configuration
REQ-024 With macro SEG7_SCAN_BLANK_EN defined, digit i (i=1..3) SHALL show 7'b0000000 when it and all higher display digits are 0; digit0 never blanked.
REQ-025 Without SEG7_SCAN_BLANK_EN, all four digits SHALL always be decoded; no blanking logic present.

Structure
REQ-026 A shared package SHALL hold the digit count (4), the BCD digit width (4), the segment width (7) and the blank pattern constant.
REQ-027 The BCD-to-segment decode SHALL be the team's existing seg7 sub-module (counter[3:0] -> segments[6:0]), one instance fed by the muxed digit, with >9 forced blank in this block.

Verification (SCAN_DIV=4)
REQ-028 Reset release, no load -> an_out cycles 0001,0010,0100,1000 every 4 cycles; seg_out 7'b0111111 in every slot (blanking off).
REQ-029 load digits_in=16'h1234 mid-frame -> busy=1 until next frame_done; following frame shows 4,3,2,1 on an_out bits 0..3.
REQ-030 load 16'h1111 then 16'h5678 in same frame -> next frame shows 5678 only; 1111 never displayed.
REQ-031 load 16'h0907 on frame_done cycle -> busy stays 0; next frame shows 7,0,9,0 as blank-free (digit3 blank with SEG7_SCAN_BLANK_EN).
REQ-032 SEG7_SCAN_BLANK_EN defined, load 16'h0005 -> digits 3..1 seg_out 7'b0000000, digit0 7'b1101101; load 16'h00A0 -> digit1 blank (invalid), digit0 7'b0111111.
REQ-033 rst_n low during slot 2 with busy=1 -> next cycle all outputs 0, busy 0; after release display shows 0000.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared digit/segment widths, blank pattern and BCD validity helper
package seg7_scan_driver_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;
  function automatic logic is_valid_bcd(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/seg7_scan_driver_seg7.sv
// seg7_scan_driver_seg7: BCD digit to active-high gfedcba segment decode
module seg7_scan_driver_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [BCD_W-1:0] i_counter,
  output logic [SEG_W-1:0] o_segments
);
  // pure lookup; codes above 9 come out blank
  always_comb begin
    case (i_counter)
      4'd0:    o_segments = 7'b0111111;
      4'd1:    o_segments = 7'b0000110;
      4'd2:    o_segments = 7'b1011011;
      4'd3:    o_segments = 7'b1001111;
      4'd4:    o_segments = 7'b1100110;
      4'd5:    o_segments = 7'b1101101;
      4'd6:    o_segments = 7'b1111101;
      4'd7:    o_segments = 7'b0000111;
      4'd8:    o_segments = 7'b1111111;
      4'd9:    o_segments = 7'b1101111;
      default: o_segments = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg scanner with tear-free frame-boundary updates; define SEG7_SCAN_BLANK_EN for leading-zero blanking
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd10_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits_in,
  input  logic                        load,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic                        busy,
  output logic                        frame_done
);
  logic [15:0]                 r_presc;
  logic [1:0]                  r_slot;
  logic [NUM_DIGITS*BCD_W-1:0] r_pend;
  logic [NUM_DIGITS*BCD_W-1:0] r_disp;
  logic                        r_busy;
  logic [SEG_W-1:0]            r_seg;
  logic [NUM_DIGITS-1:0]       r_an;
  logic                        w_tick;
  logic                        w_frame;
  logic [BCD_W-1:0]            w_digit;
  logic [SEG_W-1:0]            w_dec;
  logic [SEG_W-1:0]            w_seg;

  assign w_tick  = r_presc == SCAN_DIV - 16'd1;
  assign w_frame = w_tick && (r_slot == 2'd3);
  assign w_digit = r_disp[{r_slot, 2'b00} +: BCD_W];

  seg7_scan_driver_seg7 u_seg7 (
    .i_counter (w_digit),
    .o_segments(w_dec)
  );

`ifdef SEG7_SCAN_BLANK_EN
  logic w_lead_zero;
  // digit i>0 is a leading zero when it and every higher digit are zero
  assign w_lead_zero = (r_slot != 2'd0) && ((r_disp >> {r_slot, 2'b00}) == 16'd0);
  assign w_seg = (w_lead_zero || !is_valid_bcd(w_digit)) ? SEG_BLANK : w_dec;
`else
  assign w_seg = is_valid_bcd(w_digit) ? w_dec : SEG_BLANK;
`endif

  // free-running prescaler and slot index; nothing stalls the scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_slot  <= '0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      r_slot  <= r_slot + {1'b0, w_tick};
    end
  end

  // loads land in pending; display only moves at a frame boundary, a load on that very cycle goes straight through
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_disp <= '0;
      r_busy <= 1'b0;
    end else begin
      if (load) r_pend <= digits_in;
      if (w_frame) begin
        r_disp <= load ? digits_in : r_pend;
        r_busy <= 1'b0;
      end else if (load) begin
        r_busy <= 1'b1;
      end
    end
  end

  // anode and segments registered together so they always switch in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= '0;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= 4'b0001 << r_slot;
      r_seg <= w_seg;
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign busy       = r_busy;
  assign frame_done = w_frame && rst_n;
endmodule
